// File: rtl/imem_loader.sv
// imem_loader: receives a byte-serial program image and writes 16-bit words into instruction memory,
// holding the CPU for the whole load and verifying an XOR checksum trailer.
module imem_loader #(
  parameter int ADDR_W     = 6,
  parameter int START_ADDR = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_data_o,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              load_err_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int REM_W = ADDR_W + 1;
  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, WRITE, CSUM, DONE} state_t;
  state_t            state_q, state_d;
  logic [REM_W-1:0]  rem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic [7:0]        hi_q, csum_q;
  logic              ready_q, we_q, hold_q, done_q, err_q;
  logic              xfer, oversize;
  assign xfer        = in_valid_i && ready_q;
  assign oversize    = 32'(in_data_i) > DEPTH;
  assign in_ready_o  = ready_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign cpu_hold_o  = hold_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? COUNT : IDLE;
      COUNT:   state_d = xfer ? (oversize ? DONE : HI) : COUNT;
      HI:      state_d = xfer ? LO : HI;
      LO:      state_d = xfer ? WRITE : LO;
      WRITE:   state_d = (rem_q == REM_W'(1)) ? CSUM : HI;
      CSUM:    state_d = xfer ? DONE : CSUM;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= ADDR_W'(START_ADDR);
      data_q  <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d inside {COUNT, HI, LO, CSUM};
      we_q    <= state_d == WRITE;
      hold_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      if (state_q == IDLE && start_i) begin
        err_q  <= 1'b0;
        csum_q <= '0;
        addr_q <= ADDR_W'(START_ADDR);
      end
      if (state_q == COUNT && xfer) begin
        rem_q <= (in_data_i == 8'd0) ? REM_W'(DEPTH) : REM_W'(in_data_i);
        if (oversize) err_q <= 1'b1;
      end
      if (state_q == HI && xfer) begin
        hi_q   <= in_data_i;
        csum_q <= csum_q ^ in_data_i;
      end
      if (state_q == LO && xfer) begin
        data_q <= {hi_q, in_data_i};
        csum_q <= csum_q ^ in_data_i;
      end
      if (state_q == WRITE) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - REM_W'(1);
      end
      if (state_q == CSUM && xfer) err_q <= in_data_i != csum_q;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random program frames checked against a frame-level model of the expected writes.
module tb_imem_loader;
  logic        clock = 0, reset = 0, start = 0, in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready_a, mem_we_a, cpu_hold_a, load_done_a, load_err_a;
  logic        in_ready_b, mem_we_b, cpu_hold_b, load_done_b, load_err_b;
  logic [5:0]  mem_addr_a, mem_addr_b;
  logic [15:0] mem_data_a, mem_data_b;
  logic [7:0]  frame_q[$];
  logic [15:0] words_q[$];
  logic [21:0] wr0_q[$], wr1_q[$];
  int tests = 0, fails = 0, overlap = 0, hold_bad = 0;

  imem_loader #(.ADDR_W(6), .START_ADDR(0)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a), .mem_data_o(mem_data_a),
    .cpu_hold_o(cpu_hold_a), .load_done_o(load_done_a), .load_err_o(load_err_a));
  imem_loader #(.ADDR_W(6), .START_ADDR(62)) dut_w (
    .clock_i(clock), .reset_i(reset), .start_i(start), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b), .mem_data_o(mem_data_b),
    .cpu_hold_o(cpu_hold_b), .load_done_o(load_done_b), .load_err_o(load_err_b));

  always #5 clock = ~clock;

  always @(negedge clock) if (reset) begin
    if (mem_we_a) wr0_q.push_back({mem_addr_a, mem_data_a});
    if (mem_we_b) wr1_q.push_back({mem_addr_b, mem_data_b});
    if (mem_we_a && in_ready_a) overlap++;
  end

  function automatic void make_frame(input int n_byte, input bit bad);
    logic [7:0] x;
    logic [15:0] w;
    int n;
    frame_q.delete();
    words_q.delete();
    frame_q.push_back(8'(n_byte));
    if (n_byte > 64) return;
    n = (n_byte == 0) ? 64 : n_byte;
    x = 0;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      words_q.push_back(w);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[7:0]);
      x = x ^ w[15:8] ^ w[7:0];
    end
    frame_q.push_back(bad ? x ^ (8'h01 << $urandom_range(7)) : x);
  endfunction

  task automatic feed(input int cnt, input bit throttle, input bit poke);
    int idx = 0, cyc = 0;
    bit x;
    while (idx < cnt && cyc < 2000) begin
      in_data  = frame_q[idx];
      in_valid = !throttle || (cyc % 2 == 0) || !in_ready_a;
      start    = poke && idx == 1;
      x = in_valid && in_ready_a;
      if (!cpu_hold_a) hold_bad++;
      @(negedge clock);
      cyc++;
      if (x) idx++;
    end
    in_valid = 0;
    start = 0;
    tests++;
    if (idx < cnt) begin
      fails++;
      $display("FAIL feed_timeout: consumed %0d bytes, required %0d", idx, cnt);
    end
  endtask

  task automatic chk_writes(input logic [21:0] got[$], input int base, input string nm);
    logic [21:0] want;
    bit bad;
    bad = got.size() != words_q.size();
    tests++;
    if (bad) $display("FAIL %s write_count: got %0d, required %0d", nm, got.size(), words_q.size());
    for (int i = 0; i < got.size() && !bad; i++) begin
      want = {6'((base + i) % 64), words_q[i]};
      if (got[i] !== want) begin
        bad = 1;
        $display("FAIL %s write %0d: got addr/data %h, required %h", nm, i, got[i], want);
      end
    end
    if (bad) fails++;
  endtask

  task automatic run_load(input string nm, input bit throttle, input bit poke, input bit exp_err);
    int k = 0;
    wr0_q.delete();
    wr1_q.delete();
    hold_bad = 0;
    start = 1;
    @(negedge clock);
    start = 0;
    tests++;
    if (load_err_a !== 1'b0) begin fails++; $display("FAIL %s err_clear: got %b, required 0", nm, load_err_a); end
    feed(frame_q.size(), throttle, poke);
    while (!load_done_a && k < 20) begin
      if (!cpu_hold_a) hold_bad++;
      @(negedge clock);
      k++;
    end
    tests++;
    if (load_done_a !== 1'b1) begin fails++; $display("FAIL %s load_done: got %b, required 1", nm, load_done_a); end
    if (!cpu_hold_a) hold_bad++;
    tests++;
    if (hold_bad != 0) begin fails++; $display("FAIL %s cpu_hold: %0d low cycles, required 0", nm, hold_bad); end
    tests++;
    if (load_err_a !== exp_err) begin fails++; $display("FAIL %s load_err: got %b, required %b", nm, load_err_a, exp_err); end
    @(negedge clock);
    tests++;
    if (load_done_a !== 1'b0 || cpu_hold_a !== 1'b0) begin
      fails++;
      $display("FAIL %s release: done=%b hold=%b, required 0 0", nm, load_done_a, cpu_hold_a);
    end
    tests++;
    if (load_err_a !== exp_err) begin fails++; $display("FAIL %s err_sticky: got %b, required %b", nm, load_err_a, exp_err); end
    chk_writes(wr0_q, 0, nm);
    chk_writes(wr1_q, 62, {nm, "_wrap"});
  endtask

  task automatic test_reset();
    tests++;
    if ({in_ready_a, mem_we_a, cpu_hold_a, load_done_a, load_err_a} !== 5'b0 || mem_addr_a !== 6'd0 ||
        mem_data_a !== 16'h0 || mem_addr_b !== 6'd62) begin
      fails++;
      $display("FAIL reset: rdy=%b we=%b hold=%b done=%b err=%b addr=%0d data=%h addr_w=%0d, required all 0, addr_w=62",
               in_ready_a, mem_we_a, cpu_hold_a, load_done_a, load_err_a, mem_addr_a, mem_data_a, mem_addr_b);
    end
  endtask

  task automatic test_basic();
    frame_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    words_q = '{16'h1234, 16'hABCD};
    run_load("basic", 0, 0, 0);
  endtask

  task automatic test_bad_csum();
    frame_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    words_q = '{16'h1234, 16'hABCD};
    run_load("bad_csum", 0, 0, 1);
    repeat (3) @(negedge clock);
    tests++;
    if (load_err_a !== 1'b1) begin fails++; $display("FAIL bad_csum idle_sticky: got %b, required 1", load_err_a); end
  endtask

  task automatic test_oversize();
    make_frame(65, 0);
    run_load("oversize65", 0, 0, 1);
    make_frame($urandom_range(66, 255), 0);
    run_load("oversize_rnd", 0, 0, 1);
  endtask

  task automatic test_full();
    make_frame(0, 0);
    run_load("full", 0, 0, 0);
  endtask

  task automatic test_wrap();
    make_frame(3, 0);
    run_load("wrap3", 0, 0, 0);
  endtask

  task automatic test_throttle();
    for (int r = 0; r < 3; r++) begin
      make_frame($urandom_range(1, 6), 0);
      run_load("throttle", 1, 0, 0);
    end
    tests++;
    if (overlap != 0) begin fails++; $display("FAIL ready_in_write: %0d cycles, required 0", overlap); end
  endtask

  task automatic test_random();
    bit bad;
    for (int r = 0; r < 6; r++) begin
      bad = 1'($urandom_range(0, 1));
      make_frame($urandom_range(1, 10), bad);
      run_load("random", r % 2 == 1, 0, bad);
    end
  endtask

  task automatic test_reset_mid();
    make_frame(3, 0);
    wr0_q.delete();
    wr1_q.delete();
    start = 1;
    @(negedge clock);
    start = 0;
    feed(3, 0, 0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    test_reset();
    reset = 1;
    tests++;
    if (wr0_q.size() != 1 || wr0_q[0] !== {6'd0, words_q[0]}) begin
      fails++;
      $display("FAIL reset_mid writes: got %0d writes, required 1 at addr0=%h", wr0_q.size(), words_q[0]);
    end
    make_frame($urandom_range(1, 5), 0);
    run_load("after_reset", 0, 0, 0);
  endtask

  task automatic test_ignored_start();
    make_frame(4, 0);
    run_load("ignored_start", 0, 1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1;
    @(negedge clock);
    test_basic();
    test_bad_csum();
    test_oversize();
    test_full();
    test_wrap();
    test_throttle();
    test_random();
    test_reset_mid();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
